// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM states, access encodings and wait-counter width for data_mem_ctrl
package data_mem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  localparam logic SZ_BYTE  = 1'b0;
  localparam logic SZ_WORD  = 1'b1;
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam int   CNT_W    = 4;
endpackage

// File: rtl/data_mem_ctrl_ram.sv
// dm_ram: word-organised data RAM with per-byte-lane write enables and registered read, no reset
module dm_ram #(
  parameter int WORDS = 64,
  parameter int AW    = 6
) (
  input  logic          i_clk,
  input  logic [3:0]    i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [WORDS];
  // lane-masked write and synchronous read share one edge
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++)
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    if (i_re) o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage data-memory responder with wait states; DATA_MEM_ALIGN_CHECK_EN adds fault_o for misaligned words
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        enable_i,
  input  logic        rw_i,
  input  logic        size_i,
  input  logic        load_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        load_o,
  output logic        stall_o,
  output logic        done_o
`ifdef DATA_MEM_ALIGN_CHECK_EN
  ,
  output logic        fault_o
`endif
);
  localparam int ADDR_W = $clog2(DEPTH_BYTES);
  localparam int WA_W   = (ADDR_W > 2) ? ADDR_W - 2 : 1;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_eff;
  logic [31:0] r_wdata, r_rdata, w_q, w_rd, w_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic r_rw, r_size, r_load, w_acc, w_fault, w_unused;
  logic [3:0] w_lanes;
  logic [WA_W-1:0] w_widx;
  assign w_unused = ^addr_i[31:ADDR_W];
`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign w_fault = r_size == SZ_WORD && r_eff[1:0] != 2'b00;
  assign fault_o = r_state == S_DONE && w_fault;
`else
  assign w_fault = 1'b0;
`endif
  assign w_acc   = r_state == S_WAIT && r_cnt == '0;
  assign w_widx  = WA_W'(r_eff >> 2);
  assign w_lanes = r_size == SZ_WORD ? 4'hF : 4'b1000 >> r_eff[1:0];
  assign w_wdata = r_size == SZ_WORD ? r_wdata : {4{r_wdata[7:0]}};
  assign w_rd    = w_fault ? 32'h0 : r_size == SZ_WORD ? w_q : {24'h0, 8'(w_q >> {~r_eff[1:0], 3'b000})};
  assign rdata_o = (r_state == S_DONE && (r_rw == RW_READ || w_fault)) ? w_rd : r_rdata;
  dm_ram #(.WORDS(DEPTH_BYTES / 4), .AW(WA_W)) u_ram (
    .i_clk  (CLK),
    .i_we   ((w_acc && r_rw == RW_WRITE && !w_fault) ? w_lanes : 4'h0),
    .i_re   (w_acc && r_rw == RW_READ),
    .i_addr (w_widx),
    .i_wdata(w_wdata),
    .o_rdata(w_q)
  );
  // state register, request latch, wait countdown and held read data
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_eff   <= '0;
      r_wdata <= '0;
      r_rw    <= 1'b0;
      r_size  <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdata <= rdata_o;
      if (r_state == S_IDLE && enable_i) begin
        r_eff   <= addr_i[ADDR_W-1:0];
        r_wdata <= wdata_i;
        r_rw    <= rw_i;
        r_size  <= size_i;
        r_load  <= load_i;
        r_cnt   <= CNT_W'(WAIT_STATES);
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
  // next state and handshake outputs
  always_comb begin
    w_next  = r_state == S_IDLE ? (enable_i ? S_WAIT : S_IDLE) : r_state == S_WAIT ? (r_cnt == '0 ? S_DONE : S_WAIT) : S_IDLE;
    stall_o = r_state == S_IDLE ? enable_i : r_state == S_WAIT;
    done_o  = r_state == S_DONE;
    load_o  = r_state == S_DONE && r_load;
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl (DEPTH_BYTES=256, WAIT_STATES=1)
module tb_data_mem_ctrl;
  typedef struct {
    logic [31:0] rd;
    logic        ld;
    logic        ft;
  } exp_t;
  logic CLK = 1'b0, CLR = 1'b1, enable_i = 1'b0, rw_i = 1'b0, size_i = 1'b0, load_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [31:0] rdata_o;
  logic load_o, stall_o, done_o, fault_o;
  int checks = 0, errors = 0;
  logic [31:0] last_rd = '0;
  exp_t q[$];
`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
  assign fault_o = 1'b0;
`endif
  data_mem_ctrl #(.DEPTH_BYTES(256), .WAIT_STATES(1)) dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .enable_i(enable_i),
    .rw_i    (rw_i),
    .size_i  (size_i),
    .load_i  (load_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .load_o  (load_o),
    .stall_o (stall_o),
    .done_o  (done_o)
`ifdef DATA_MEM_ALIGN_CHECK_EN
    ,
    .fault_o (fault_o)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge CLK) begin
    exp_t e;
    if (done_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending access");
      end else begin
        e = q.pop_front();
        chk("rdata", rdata_o, e.rd);
        chk("load", {31'b0, load_o}, {31'b0, e.ld});
        chk("fault", {31'b0, fault_o}, {31'b0, e.ft});
      end
    end
  end
  task automatic acc(input logic rw, input logic sz, input logic ld, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic ft);
    exp_t e;
    int n, stalls;
    bit got;
    e.ld = ld;
    e.ft = ft;
    e.rd = ft ? 32'h0 : (rw ? last_rd : exp_rd);
    last_rd = e.rd;
    q.push_back(e);
    @(posedge CLK);
    #1;
    rw_i = rw; size_i = sz; load_i = ld; addr_i = a; wdata_i = wd; enable_i = 1'b1;
    n = 0; stalls = 0; got = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (stall_o) stalls++;
      if (done_o) begin
        got = 1'b1;
        break;
      end
      n++;
    end
    enable_i = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done_o expected done for addr %h", a);
      void'(q.pop_front());
    end else begin
      chk("done_cycle", n, 3);
      chk("stall_cycles", stalls, 3);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] byte_exp [4];
    byte_exp = '{32'hDE, 32'hAD, 32'hBE, 32'hEF};
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rdata", rdata_o, 0);
    chk("rst_flags", {28'b0, load_o, stall_o, done_o, fault_o}, 0);
    CLR = 1'b0;
    acc(1, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0);
    acc(0, 1, 1, 32'h10, 0, 32'hDEADBEEF, 0);
    for (int i = 0; i < 4; i++) acc(0, 0, i[0], 32'h10 + i, 0, byte_exp[i], 0);
    acc(1, 0, 1, 32'h12, 32'hAABBCC55, 0, 0);
    acc(0, 1, 1, 32'h10, 0, 32'hDEAD55EF, 0);
    acc(0, 1, 0, 32'h110, 0, 32'hDEAD55EF, 0);
    acc(0, 0, 1, 32'hFFFFFF12, 0, 32'h55, 0);
    acc(1, 0, 0, 32'h13, 32'h00000077, 0, 0);
    acc(0, 1, 1, 32'h10, 0, 32'hDEAD5577, 0);
    acc(1, 1, 0, 32'h20, 32'hCAFEF00D, 0, 0);
    acc(0, 1, 0, 32'h20, 0, 32'hCAFEF00D, 0);
    @(posedge CLK);
    #1;
    rw_i = 1; size_i = 1; load_i = 1; addr_i = 32'h20; wdata_i = 32'h12345678; enable_i = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b1;
    enable_i = 1'b0;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    chk("clr_rdata", rdata_o, 0);
    chk("clr_flags", {28'b0, load_o, stall_o, done_o, fault_o}, 0);
    last_rd = '0;
    repeat (3) begin
      @(negedge CLK);
      chk("idle_stall", {31'b0, stall_o}, 0);
    end
    acc(0, 1, 1, 32'h20, 0, 32'hCAFEF00D, 0);
    acc(1, 1, 0, 32'h22, 32'h11223344, 0, ALIGN);
    acc(0, 1, 1, 32'h20, 0, ALIGN ? 32'hCAFEF00D : 32'h11223344, 0);
    acc(0, 0, 0, 32'h23, 0, ALIGN ? 32'h0D : 32'h44, 0);
    repeat (5) @(posedge CLK);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

MEM-stage data-memory responder: consumes the memory control bits (enable, rw, size, load) that the EX/MEM register presents, and performs the byte or word access against an internal synchronous data RAM. It holds the pipeline with `stall_o` for a configurable number of wait states. When the access completes, it returns read data to the MEM/WB path. It sits directly downstream of the EX/MEM register and upstream of the MEM/WB register.

## Interface
- `DEPTH_BYTES`, default 256: data RAM size in bytes; must be a power of two and at least 4.
- `WAIT_STATES`, default 1: extra wait cycles per access, range 0–15.
- `CLK` in 1: the single clock; all state changes on the rising edge.
- `CLR` in 1: synchronous, active-high reset.
- `enable_i` in 1: a memory access is requested this cycle.
- `rw_i` in 1: 0 = read, 1 = write.
- `size_i` in 1: 0 = byte, 1 = word.
- `load_i` in 1: the access is a register-file load; it is passed through as `load_o`.
- `addr_i` in 32: byte address.
- `wdata_i` in 32: store data. A byte store uses `[7:0]`.
- `rdata_o` out 32: read data.
- `load_o` out 1: latched `load_i`, valid with `done_o`.
- `stall_o` out 1: the pipeline must hold the EX/MEM and earlier stages.
- `done_o` out 1: one-cycle pulse when the access completes.
- `fault_o` out 1: only present when `DATA_MEM_ALIGN_CHECK_EN` is defined.

## Operation
- Every output resets to 0. The FSM resets to IDLE. RAM contents are not reset.
- FSM states are IDLE, WAIT and DONE.
- IDLE:
  - `stall_o = enable_i`, combinational.
  - If `enable_i` is high: latch `addr`, `wdata`, `rw`, `size` and `load`, set `cnt = WAIT_STATES`, and go to WAIT.
- WAIT:
  - `stall_o = 1`.
  - While `cnt != 0`, decrement `cnt`.
  - When `cnt == 0`, perform the RAM access and go to DONE.
- DONE:
  - `stall_o = 0` and `done_o = 1`.
  - `rdata_o` and `load_o` are valid.
  - `enable_i` is ignored, because it still carries the same held request.
  - Always go to IDLE next.
- Address mapping: `eff = addr & (DEPTH_BYTES-1)`. Upper address bits wrap silently.
- Byte order is big-endian: for word address W, byte W maps to `[31:24]` and byte W+3 maps to `[7:0]`.
- A word access uses `eff[ADDR_W-1:2]` and ignores `eff[1:0]`, unless the alignment check is enabled.
- Byte read: the selected byte is zero-extended into `rdata_o`.
- Word read: the full 32-bit word goes to `rdata_o`.
- Byte write: only the lane selected by `eff[1:0]` is enabled.
- Word write: all four lanes are enabled.
- `rdata_o` updates only on reads. After a write it holds its previous value.
- `CLR` asserted in any state forces IDLE and zeroes all outputs. A write that has not yet been performed in WAIT is discarded. A write already performed is not undone.
- Requests arriving while the FSM is in WAIT or DONE are not queued. The pipeline is frozen by `stall_o`.

## Timing
- Acceptance happens in cycle 0, the IDLE cycle with `enable_i` high.
- WAIT lasts `WAIT_STATES+1` cycles. The RAM access occurs on the last WAIT edge.
- `done_o` is high in cycle `WAIT_STATES+2`.
- `stall_o` is high in cycles 0 through `WAIT_STATES+1`, i.e. `WAIT_STATES+2` cycles.
- With `WAIT_STATES=0`, cycle 0 stalls, cycle 1 stalls and accesses, and cycle 2 is DONE.
- Back-to-back accesses: the earliest next acceptance is the cycle after DONE.
- Throughput is one access per `WAIT_STATES+3` cycles.
- `enable_i=0` in IDLE leaves all outputs at 0, except `rdata_o`, which holds.

## Configuration
- `DATA_MEM_ALIGN_CHECK_EN` defined:
  - A word access with `eff[1:0] != 0` is a fault.
  - The RAM is not written.
  - In DONE, `rdata_o = 0` and `fault_o = 1` for that single cycle.
  - Stall and done timing are unchanged.
- `DATA_MEM_ALIGN_CHECK_EN` not defined:
  - `fault_o` does not exist.
  - Misaligned word accesses silently align down.

## Structure
- Package `data_mem_pkg` holds:
  - FSM state enum.
  - Size encodings `SZ_BYTE`/`SZ_WORD`.
  - RW encodings `RW_READ`/`RW_WRITE`.
  - Wait-counter width constant of 4 bits.
- Sub-module `dm_ram`:
  - DEPTH_BYTES/4 words of 32 bits.
  - Synchronous write with a 4-bit lane enable.
  - Synchronous read.
  - No reset.
- The top level contains the FSM, the request latches and the lane steering and extension logic.

## Test plan
- `WAIT_STATES=1`: word write to 0x10 with data 0xDEADBEEF, then word read from 0x10 → `stall_o` high for 3 cycles each, `done_o` high in cycle 3, `rdata_o=0xDEADBEEF`.
- Byte reads 0x10–0x13 after the above → 0x000000DE, 0x000000AD, 0x000000BE, 0x000000EF.
- Byte write 0x55 to 0x12, then word read from 0x10 → 0xDEAD55EF. `load_o` matches the `load_i` sent with each request.
- Address 0x110 with `DEPTH_BYTES=256` → aliases to 0x10, and the read returns the same word.
- `CLR` pulsed in the first WAIT cycle of a word write of 0x12345678 to 0x20 → IDLE next cycle, all outputs 0, and a later read of 0x20 returns the prior contents.
- With `DATA_MEM_ALIGN_CHECK_EN`: word write to 0x22 → `fault_o=1` and `rdata_o=0` in DONE, and memory is unchanged. Without the macro, the same write lands at 0x20.
